// File: rtl/wb_uart_pkg.sv
// wb_uart_pkg: state encoding and wb_uart register map shared by wb_uart_sched.
package wb_uart_pkg;
    typedef enum logic [1:0] {ST_GAP, ST_POLL, ST_RXRD, ST_TXWR} state_e;
    localparam logic [3:0] UCR_OFS = 4'h0;
    localparam logic [3:0] DATA_OFS = 4'h4;
    localparam int RX_AVAIL = 0;
    localparam int RX_ERROR = 1;
    localparam int TX_BUSY = 4;
    function automatic logic [31:0] reg_adr(input logic [31:0] base, input logic [3:0] ofs);
        return base + {28'b0, ofs};
    endfunction
endpackage

// File: rtl/wb_uart_sched_rr_arb2.sv
// rr_arb2: two-way TX arbiter; round-robin when WB_UART_SCHED_RR_EN is defined, else tx0 fixed priority.
module rr_arb2
    import wb_uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       gnt
);
`ifdef WB_UART_SCHED_RR_EN
    logic ptr_q, ptr_d;
    always_comb begin
        ptr_d = advance ? ~ptr_q : ptr_q;
        gnt = req[ptr_q] ? ptr_q : ~ptr_q;
    end
    always_ff @(posedge clk) begin
        ptr_q <= reset ? 1'b0 : ptr_d;
    end
`else
    logic unused_arb;
    assign unused_arb = ^{clk, reset, req[1], advance};
    assign gnt = ~req[0];
`endif
endmodule

// File: rtl/wb_uart_sched.sv
// wb_uart_sched: Wishbone master polling a wb_uart slave for two TX requesters and one RX consumer.
// Define WB_UART_SCHED_RR_EN for round-robin TX arbitration; default is fixed priority to tx0.
module wb_uart_sched
    import wb_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADR    = 32'hF000_0000,
    parameter int          POLL_GAP    = 4,
    parameter int          ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx0_valid,
    input  logic [7:0]  tx0_data,
    output logic        tx0_ready,
    input  logic        tx1_valid,
    input  logic [7:0]  tx1_data,
    output logic        tx1_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic        rx_err,
    input  logic        rx_ready,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [31:0] m_adr_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
    output logic        bus_err
);
    localparam logic [7:0] GAP_INIT = 8'(POLL_GAP);
    localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);
    state_e state_q, state_d;
    logic [7:0] gap_q, gap_d, to_q, to_d, rx_data_q, rx_data_d;
    logic [31:0] adr_q, adr_d, dat_q, dat_d;
    logic [3:0] sel_q, sel_d;
    logic cyc_q, cyc_d, we_q, we_d, gnt_q, gnt_d, rx_error_q, rx_error_d;
    logic rx_valid_q, rx_valid_d, rx_err_q, rx_err_d, bus_err_q, bus_err_d;
    logic tx0_ready_q, tx0_ready_d, tx1_ready_q, tx1_ready_d;
    logic done, tmo, rx_go, tx_go, gap_end, start, poll_ack, tx_cap, rx_load, tx_acc, arb_gnt;
    logic unused_dat;
    assign unused_dat = ^m_dat_i[31:8];
    // A bus cycle ends on ack or after ACK_TIMEOUT cycles of waiting, whichever first.
    assign done = cyc_q & m_ack_i;
    assign tmo = cyc_q & ~m_ack_i & (to_q == TO_LAST);
    assign rx_go = m_dat_i[RX_AVAIL] & ~rx_valid_q;
    assign tx_go = ~m_dat_i[TX_BUSY] & (tx0_valid | tx1_valid);
    assign gap_end = (state_q == ST_GAP) && (gap_q == 8'd1);
    assign start = gap_end | (((state_q == ST_RXRD) || (state_q == ST_TXWR)) && !cyc_q);
    assign poll_ack = (state_q == ST_POLL) && done;
    assign tx_cap = poll_ack && !rx_go && tx_go;
    assign rx_load = (state_q == ST_RXRD) && done;
    assign tx_acc = (state_q == ST_TXWR) && done;
    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     ({tx1_valid, tx0_valid}),
        .advance (tx_acc),
        .gnt     (arb_gnt)
    );
    always_ff @(posedge clk) begin
        state_q <= reset ? ST_GAP : state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_GAP:  state_d = gap_end ? ST_POLL : ST_GAP;
            ST_POLL: state_d = done ? (rx_go ? ST_RXRD : tx_go ? ST_TXWR : ST_GAP) : tmo ? ST_GAP : ST_POLL;
            default: state_d = (done | tmo) ? ST_GAP : state_q;
        endcase
    end
    // Data/TX bus cycles start one cycle after the poll ack so stb never stays high past an ack.
    always_comb begin
        gap_d = (state_q == ST_GAP) ? gap_q - 8'd1 : GAP_INIT;
        to_d = start ? 8'd0 : cyc_q ? to_q + 8'd1 : to_q;
        cyc_d = start | (cyc_q & ~done & ~tmo);
        we_d = start ? (state_q == ST_TXWR) : we_q;
        adr_d = start ? reg_adr(BASE_ADR, (state_q == ST_GAP) ? UCR_OFS : DATA_OFS) : adr_q;
        sel_d = 4'hF;
        gnt_d = tx_cap ? arb_gnt : gnt_q;
        dat_d = tx_cap ? {24'b0, arb_gnt ? tx1_data : tx0_data} : dat_q;
        rx_error_d = poll_ack ? m_dat_i[RX_ERROR] : rx_error_q;
        rx_valid_d = rx_load | (rx_valid_q & ~rx_ready);
        rx_data_d = rx_load ? m_dat_i[7:0] : rx_data_q;
        rx_err_d = rx_load ? rx_error_q : rx_err_q;
        tx0_ready_d = tx_acc & ~gnt_q;
        tx1_ready_d = tx_acc & gnt_q;
        bus_err_d = bus_err_q | tmo;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            gap_q <= GAP_INIT;
            to_q <= '0;
            cyc_q <= 1'b0;
            we_q <= 1'b0;
            adr_q <= '0;
            sel_q <= '0;
            dat_q <= '0;
            gnt_q <= 1'b0;
            rx_error_q <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q <= '0;
            rx_err_q <= 1'b0;
            tx0_ready_q <= 1'b0;
            tx1_ready_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            gap_q <= gap_d;
            to_q <= to_d;
            cyc_q <= cyc_d;
            we_q <= we_d;
            adr_q <= adr_d;
            sel_q <= sel_d;
            dat_q <= dat_d;
            gnt_q <= gnt_d;
            rx_error_q <= rx_error_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q <= rx_data_d;
            rx_err_q <= rx_err_d;
            tx0_ready_q <= tx0_ready_d;
            tx1_ready_q <= tx1_ready_d;
            bus_err_q <= bus_err_d;
        end
    end
    assign m_cyc_o = cyc_q;
    assign m_stb_o = cyc_q;
    assign m_we_o = we_q;
    assign m_adr_o = adr_q;
    assign m_sel_o = sel_q;
    assign m_dat_o = dat_q;
    assign tx0_ready = tx0_ready_q;
    assign tx1_ready = tx1_ready_q;
    assign rx_valid = rx_valid_q;
    assign rx_data = rx_data_q;
    assign rx_err = rx_err_q;
    assign bus_err = bus_err_q;
endmodule

// File: tb/tb_wb_uart_sched.sv
// tb_wb_uart_sched: drives wb_uart_sched against a behavioural UART slave with txd->rxd loopback.
module tb_wb_uart_sched;
    localparam logic [31:0] BASE = 32'hF000_0000;
    localparam int BUSY_CYC = 12;
    logic clk = 0, reset = 1;
    logic tx0_valid = 0, tx1_valid = 0, rx_ready = 0;
    logic [7:0] tx0_data = 0, tx1_data = 0;
    logic tx0_ready, tx1_ready, rx_valid, rx_err, bus_err;
    logic [7:0] rx_data;
    logic m_cyc_o, m_stb_o, m_we_o;
    logic [31:0] m_adr_o, m_dat_o;
    logic [3:0] m_sel_o;
    logic [31:0] m_dat_i = 0;
    logic m_ack_i = 0;
    logic [83:0] outs;
    int checks = 0, passes = 0;
    always #5 clk = ~clk;
    assign outs = {m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o, m_sel_o, tx0_ready, tx1_ready,
                   rx_valid, rx_data, rx_err, bus_err};
    wb_uart_sched dut (
        .clk(clk), .reset(reset),
        .tx0_valid(tx0_valid), .tx0_data(tx0_data), .tx0_ready(tx0_ready),
        .tx1_valid(tx1_valid), .tx1_data(tx1_data), .tx1_ready(tx1_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err), .rx_ready(rx_ready),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o),
        .m_sel_o(m_sel_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
        .bus_err(bus_err)
    );
    // Behavioural wb_uart: UCR/DATA registers, tx_busy window after each write, loopback into an RX queue.
    int ws = 0;
    bit kill_wr = 0, force_busy = 0, err_par = 0;
    int wcnt = 0, busy_cnt = 0, ucr_rd = 0, data_rd = 0;
    logic [8:0] tx_pend = 0;
    logic [8:0] rxq[$];
    logic [31:0] wr_q[$], wa_q[$];
    always @(posedge clk) begin
        if (reset) begin
            m_ack_i <= 0;
            wcnt <= 0;
            busy_cnt <= 0;
            rxq.delete();
        end else begin
            if (busy_cnt == 1) rxq.push_back(tx_pend);
            if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
            if (m_ack_i) m_ack_i <= 0;
            else if (m_cyc_o && m_stb_o && !(kill_wr && m_we_o)) begin
                if (wcnt < ws) wcnt <= wcnt + 1;
                else begin
                    wcnt <= 0;
                    m_ack_i <= 1;
                    if (m_we_o) begin
                        wr_q.push_back(m_dat_o);
                        wa_q.push_back(m_adr_o);
                        busy_cnt <= BUSY_CYC;
                        tx_pend <= {err_par && (^m_dat_o[7:0]), m_dat_o[7:0]};
                    end else if (m_adr_o == BASE) begin
                        ucr_rd <= ucr_rd + 1;
                        m_dat_i <= {27'b0, (busy_cnt != 0) || force_busy, 2'b0,
                                    (rxq.size() != 0) && rxq[0][8], rxq.size() != 0};
                    end else begin
                        data_rd <= data_rd + 1;
                        m_dat_i <= (rxq.size() != 0) ? {24'b0, rxq[0][7:0]} : 32'h0;
                        if (rxq.size() != 0) void'(rxq.pop_front());
                    end
                end
            end else wcnt <= 0;
        end
    end
    // Bus monitor: stb must fall right after an ack and track cyc; cyc run lengths recorded.
    bit ack_prev = 0;
    int run = 0, last_run = 0, viol = 0;
    always @(posedge clk) begin
        ack_prev <= m_ack_i;
        viol <= viol + int'((!reset && ack_prev && m_stb_o) || (m_cyc_o !== m_stb_o));
        if (m_cyc_o) run <= run + 1;
        else if (run != 0) begin
            last_run <= run;
            run <= 0;
        end
    end
    task automatic do_reset();
        tx0_valid = 0;
        tx1_valid = 0;
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
    endtask
    task automatic wait_tx(input int which, input int max, output bit got);
        got = 0;
        for (int i = 0; i < max && !got; i++) begin
            @(negedge clk);
            got = which ? tx1_ready : tx0_ready;
        end
    endtask
    task automatic test_reset();
        reset = 1;
        repeat (3) @(negedge clk);
        checks++; if (outs !== 84'h0) $display("FAIL reset_outs: got %h expected 0", outs); else passes++;
        reset = 0;
        repeat (3) begin
            @(negedge clk);
            checks++; if (m_cyc_o !== 1'b0) $display("FAIL gap_idle: cyc got %b expected 0", m_cyc_o); else passes++;
        end
        @(negedge clk);
        checks++;
        if ({m_cyc_o, m_we_o, m_adr_o, m_sel_o} !== {1'b1, 1'b0, BASE, 4'hF})
            $display("FAIL first_poll: cyc/we/adr/sel got %b %b %h %h expected 1 0 %h f", m_cyc_o, m_we_o, m_adr_o, m_sel_o, BASE);
        else passes++;
    endtask
    task automatic test_single();
        bit got;
        int n;
        do_reset();
        rx_ready = 1;
        n = wr_q.size();
        tx0_data = 8'h55;
        tx0_valid = 1;
        wait_tx(0, 200, got);
        tx0_valid = 0;
        checks++; if (got !== 1'b1) $display("FAIL single_ready: got %b expected 1", got); else passes++;
        @(negedge clk);
        checks++; if (tx0_ready !== 1'b0) $display("FAIL single_pulse: ready got %b expected 0", tx0_ready); else passes++;
        checks++;
        if (wr_q.size() != n + 1 || wr_q[n] !== 32'h55 || wa_q[n] !== BASE + 4)
            $display("FAIL single_write: count %0d data %h adr %h expected 1 00000055 %h", wr_q.size() - n, wr_q[n], wa_q[n], BASE + 4);
        else passes++;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = rx_valid;
        end
        checks++;
        if ({got, rx_data, rx_err} !== {1'b1, 8'h55, 1'b0})
            $display("FAIL single_rx: valid %b data %h err %b expected 1 55 0", got, rx_data, rx_err);
        else passes++;
    endtask
    task automatic test_pair();
        int order[$];
        int n, exp;
        do_reset();
        rx_ready = 1;
        n = wr_q.size();
        tx0_data = 8'hA1;
        tx1_data = 8'hB2;
        tx0_valid = 1;
        tx1_valid = 1;
        for (int i = 0; i < 2000 && order.size() < 4; i++) begin
            @(negedge clk);
            if (tx0_ready) order.push_back(0);
            if (tx1_ready) order.push_back(1);
        end
        tx0_valid = 0;
        tx1_valid = 0;
        checks++; if (order.size() != 4) $display("FAIL pair_count: got %0d grants expected 4", order.size()); else passes++;
        for (int k = 0; k < 4 && k < order.size(); k++) begin
`ifdef WB_UART_SCHED_RR_EN
            exp = k % 2;
`else
            exp = 0;
`endif
            checks++;
            if (order[k] != exp || wr_q[n + k] !== (exp ? 32'hB2 : 32'hA1))
                $display("FAIL pair_order%0d: grant %0d data %h expected %0d %h", k, order[k], wr_q[n + k], exp, exp ? 32'hB2 : 32'hA1);
            else passes++;
        end
    endtask
    task automatic test_rx_hold();
        bit got;
        int d0;
        logic [7:0] second;
        do_reset();
        rx_ready = 0;
        d0 = data_rd;
        tx0_data = 8'h3C;
        tx0_valid = 1;
        wait_tx(0, 200, got);
        tx0_data = 8'hC3;
        wait_tx(0, 200, got);
        tx0_valid = 0;
        repeat (100) @(negedge clk);
        checks++;
        if ({rx_valid, rx_data} !== {1'b1, 8'h3C} || data_rd - d0 != 1)
            $display("FAIL rx_hold: valid %b data %h reads %0d expected 1 3c 1", rx_valid, rx_data, data_rd - d0);
        else passes++;
        rx_ready = 1;
        @(negedge clk);
        got = 0;
        second = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = rx_valid;
            second = rx_data;
        end
        checks++;
        if ({got, second} !== {1'b1, 8'hC3} || data_rd - d0 != 2)
            $display("FAIL rx_release: valid %b data %h reads %0d expected 1 c3 2", got, second, data_rd - d0);
        else passes++;
    endtask
    task automatic test_timeout();
        bit got, hit;
        int rdy, n;
        do_reset();
        rx_ready = 1;
        n = wr_q.size();
        kill_wr = 1;
        tx0_data = 8'h7E;
        tx0_valid = 1;
        rdy = 0;
        hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            rdy += int'(tx0_ready);
            hit = bus_err;
        end
        checks++; if (hit !== 1'b1 || rdy != 0) $display("FAIL timeout_err: bus_err %b readies %0d expected 1 0", hit, rdy); else passes++;
        @(negedge clk);
        checks++; if (last_run != 15) $display("FAIL timeout_len: cyc held %0d expected 15", last_run); else passes++;
        kill_wr = 0;
        wait_tx(0, 300, got);
        tx0_valid = 0;
        checks++;
        if (got !== 1'b1 || wr_q.size() != n + 1 || wr_q[n] !== 32'h7E || bus_err !== 1'b1)
            $display("FAIL timeout_retry: ready %b writes %0d data %h bus_err %b expected 1 1 7e 1", got, wr_q.size() - n, wr_q[n], bus_err);
        else passes++;
    endtask
    task automatic test_busy();
        bit got;
        int u0, n, rdy;
        do_reset();
        force_busy = 1;
        u0 = ucr_rd;
        n = wr_q.size();
        tx0_data = 8'h99;
        tx0_valid = 1;
        rdy = 0;
        repeat (150) begin
            @(negedge clk);
            rdy += int'(tx0_ready);
        end
        checks++;
        if (wr_q.size() != n || rdy != 0 || ucr_rd - u0 <= 5)
            $display("FAIL busy_hold: writes %0d readies %0d polls %0d expected 0 0 >5", wr_q.size() - n, rdy, ucr_rd - u0);
        else passes++;
        force_busy = 0;
        wait_tx(0, 200, got);
        tx0_valid = 0;
        checks++;
        if (got !== 1'b1 || wr_q.size() != n + 1 || wr_q[n] !== 32'h99)
            $display("FAIL busy_release: ready %b writes %0d data %h expected 1 1 99", got, wr_q.size() - n, wr_q[n]);
        else passes++;
    endtask
    task automatic test_reset_mid();
        bit got, hit;
        int n;
        do_reset();
        ws = 3;
        n = wr_q.size();
        tx0_data = 8'h42;
        tx0_valid = 1;
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            hit = m_cyc_o && m_we_o;
        end
        checks++; if (hit !== 1'b1) $display("FAIL mid_reach: write cycle seen %b expected 1", hit); else passes++;
        reset = 1;
        @(negedge clk);
        checks++; if (outs !== 84'h0) $display("FAIL mid_reset: outs %h expected 0", outs); else passes++;
        reset = 0;
        wait_tx(0, 300, got);
        tx0_valid = 0;
        ws = 0;
        checks++;
        if (got !== 1'b1 || wr_q.size() != n + 1 || wr_q[n] !== 32'h42)
            $display("FAIL mid_resend: ready %b writes %0d data %h expected 1 1 42", got, wr_q.size() - n, wr_q[n]);
        else passes++;
    endtask
    task automatic test_random();
        localparam int N = 6;
        logic [7:0] q0[N], q1[N];
        logic [7:0] acc[$];
        logic [8:0] got_rx[$];
        int i0, i1, n;
        do_reset();
        ws = $urandom_range(0, 2);
        err_par = 1;
        n = wr_q.size();
        for (int k = 0; k < N; k++) begin
            q0[k] = 8'($urandom);
            q1[k] = 8'($urandom);
        end
        i0 = 0;
        i1 = 0;
        for (int c = 0; c < 20000 && !(i0 == N && i1 == N && got_rx.size() == 2 * N); c++) begin
            @(negedge clk);
            rx_ready = $urandom_range(0, 3) != 0;
            if (rx_valid && rx_ready) got_rx.push_back({rx_err, rx_data});
            if (tx0_ready) begin
                acc.push_back(tx0_data);
                i0++;
                tx0_valid = 0;
            end
            if (tx1_ready) begin
                acc.push_back(tx1_data);
                i1++;
                tx1_valid = 0;
            end
            if (!tx0_valid && i0 < N && $urandom_range(0, 3) == 0) begin
                tx0_data = q0[i0];
                tx0_valid = 1;
            end
            if (!tx1_valid && i1 < N && $urandom_range(0, 3) == 0) begin
                tx1_data = q1[i1];
                tx1_valid = 1;
            end
        end
        err_par = 0;
        rx_ready = 1;
        checks++;
        if (acc.size() != 2 * N || got_rx.size() != 2 * N || wr_q.size() != n + 2 * N)
            $display("FAIL rand_count: accepted %0d received %0d writes %0d expected %0d", acc.size(), got_rx.size(), wr_q.size() - n, 2 * N);
        else passes++;
        for (int k = 0; k < acc.size() && k < got_rx.size() && n + k < wr_q.size(); k++) begin
            checks++;
            if (wr_q[n + k] !== {24'b0, acc[k]} || got_rx[k] !== {^acc[k], acc[k]})
                $display("FAIL rand_item%0d: write %h rx %h expected %h %h", k, wr_q[n + k], got_rx[k], acc[k], {^acc[k], acc[k]});
            else passes++;
        end
        ws = 0;
    endtask
    initial begin
        test_reset();
        test_single();
        test_pair();
        test_rx_hold();
        test_timeout();
        test_busy();
        test_reset_mid();
        test_random();
        repeat (5) @(negedge clk);
        checks++; if (viol != 0) $display("FAIL bus_protocol: violations %0d expected 0", viol); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
